fetch_align_queue: RTL and testbench
====================================

FETCH_ALIGN_QUEUE -- requirements
Module: fetch_align_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/PC width.
REQ-002 SHALL have parameter DEPTH, default 8, queue capacity in 16-bit halfwords (power of two, >=4).
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch PC after reset.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low (rst=0 resets).
REQ-006 fetch_req  output  1  request for a 32-bit word from instruction memory.
REQ-007 fetch_addr  output  XLEN  word-aligned fetch address (bits[1:0]=0).
REQ-008 fetch_gnt  input  1  memory accepts request; fetch_rdata valid in the same cycle.
REQ-009 fetch_rdata  input  32  fetched word, little-endian halfwords.
REQ-010 redirect  input  1  branch/jump taken; discard queue and refetch.
REQ-011 redirect_pc  input  XLEN  target PC, halfword-aligned (bit0 ignored).
REQ-012 instr_valid  output  1  instr/instr_pc hold a complete instruction.
REQ-013 instr_ready  input  1  decode stage accepts (IF/ID write enable).
REQ-014 instr  output  32  raw instruction; compressed form zero-extended in [31:16].
REQ-015 instr_is_c  output  1  instr[1:0]!=2'b11.
REQ-016 instr_pc  output  XLEN  PC of instr.
REQ-017 instr_pc_next  output  XLEN  instr_pc+2 if compressed, else instr_pc+4.
REQ-018 count  output  $clog2(DEPTH)+1  occupied halfwords.

Function
REQ-019 Queue SHALL be a circular buffer of DEPTH halfwords, read/write pointers wrapping modulo DEPTH.
REQ-020 Head halfword with [1:0]!=11 SHALL form a compressed instruction once count>=1; [1:0]==11 SHALL require count>=2, instr={hw[head+1],hw[head]}.
REQ-021 instr_valid SHALL be 1 iff REQ-020 is met and redirect=0; instr outputs combinational from registered queue state.
REQ-022 Pop on instr_valid&instr_ready: 1 halfword (compressed) or 2; instr_pc advances by 2 or 4.
REQ-023 fetch_req SHALL be 1 iff rst=1, redirect=0 and free slots >= halfwords the grant would push (2, or 1 while skip_lo set).
REQ-024 Grant SHALL push rdata[15:0] then rdata[31:16]; if skip_lo set, push only rdata[31:16] and clear skip_lo; fetch_addr += 4.
REQ-025 Push and pop in the same cycle SHALL both take effect; count_next = count + pushed - popped, never >DEPTH or <0.
REQ-026 Latency: word granted in cycle N SHALL be visible on instr no earlier than N+1; no bypass.
REQ-027 Straddling 32-bit instruction (low half at queue tail) SHALL stay invalid until next word pushed, then valid.
REQ-028 redirect SHALL take priority over pop and grant in that cycle: count=0, pointers equal, instr_pc=redirect_pc&~1, fetch_addr=redirect_pc&~3, skip_lo=redirect_pc[1]; any same-cycle fetch_rdata discarded.
REQ-029 fetch_addr SHALL wrap modulo 2^XLEN without error.

Reset
REQ-030 While rst=0: count=0, pointers=0, skip_lo=RESET_PC[1], instr_pc=RESET_PC&~1, fetch_addr=RESET_PC&~3, fetch_req=0, instr_valid=0.
REQ-031 First fetch_req SHALL assert in the first cycle after rst rises.
REQ-032 Reset asserted mid-operation SHALL discard all queued halfwords immediately (asynchronous).

Verification
REQ-033 Reset release, gnt always 1, words 0x00A00093, 0x00108113 -> instr 0x00A00093 pc 0x0, then 0x00108113 pc 0x4, is_c=0.
REQ-034 Word 0x45014505 (two c.li) -> instr 0x00004505 pc 0x0 next 0x2, then 0x00004501 pc 0x2, each pop 1 halfword.
REQ-035 Straddle: words 0x00934505, 0x000000A0 -> c 0x4505 at pc 0, then 0x00A00093 at pc 2 valid only after second grant.
REQ-036 redirect=1 redirect_pc=0x102 while queue holds 6 halfwords -> next cycle count=0, fetch_addr=0x100, only upper half of word at 0x100 pushed, first instr_pc=0x102.
REQ-037 DEPTH=4, instr_ready=0 -> fetch_req drops at count=4, count never exceeds 4; ready=1 resumes with pointer wrap and no lost or duplicated halfwords.
REQ-038 Same-cycle grant and 32-bit pop at count=2 -> count stays 2, instr_pc += 4.

Source files
------------

// File: rtl/fetch_align_queue_if.sv
// Fetch-side and decode-side signals of the fetch align queue.
// The slave modport is the queue itself; the master modport is its environment.
interface fetch_align_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8
);
    logic                       fetch_req;
    logic [XLEN-1:0]            fetch_addr;
    logic                       fetch_gnt;
    logic [31:0]                fetch_rdata;
    logic                       redirect;
    logic [XLEN-1:0]            redirect_pc;
    logic                       instr_valid;
    logic                       instr_ready;
    logic [31:0]                instr;
    logic                       instr_is_c;
    logic [XLEN-1:0]            instr_pc;
    logic [XLEN-1:0]            instr_pc_next;
    logic [$clog2(DEPTH):0]     count;

    modport slave (
        output fetch_req, fetch_addr, instr_valid, instr, instr_is_c,
               instr_pc, instr_pc_next, count,
        input  fetch_gnt, fetch_rdata, redirect, redirect_pc, instr_ready
    );

    modport master (
        input  fetch_req, fetch_addr, instr_valid, instr, instr_is_c,
               instr_pc, instr_pc_next, count,
        output fetch_gnt, fetch_rdata, redirect, redirect_pc, instr_ready
    );
endinterface

// File: rtl/fetch_align_queue.sv
// Halfword fetch queue: turns 32-bit fetched words into aligned 16/32-bit
// instructions, handling compressed code and instructions straddling words.
module fetch_align_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 8,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic                 clk,
    input logic                 rst,
    fetch_align_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [15:0]     hw_q [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr, rd_nxt1, wr_nxt1;
    logic [CW-1:0]   cnt, free, need, push_n, pop_n;
    logic            skip_lo;
    logic [XLEN-1:0] pc_q, fa_q;
    logic [15:0]     hw0, hw1;
    logic            head_c, have, valid, pop, req, push;

    always_comb begin
        rd_nxt1 = rd_ptr + PW'(1);
        wr_nxt1 = wr_ptr + PW'(1);
        hw0     = hw_q[rd_ptr];
        hw1     = hw_q[rd_nxt1];
        head_c  = hw0[1:0] != 2'b11;
        have    = head_c ? (cnt >= CW'(1)) : (cnt >= CW'(2));
        valid   = have & ~bus.redirect;
        pop     = valid & bus.instr_ready;
        pop_n   = !pop ? '0 : (head_c ? CW'(1) : CW'(2));
        free    = CW'(DEPTH) - cnt;
        // After a redirect into the upper half of a word, only that half is kept.
        need    = skip_lo ? CW'(1) : CW'(2);
        req     = rst & ~bus.redirect & (free >= need);
        push    = req & bus.fetch_gnt;
        push_n  = push ? need : '0;
    end

    assign bus.fetch_req     = req;
    assign bus.fetch_addr    = fa_q;
    assign bus.instr_valid   = valid;
    assign bus.instr         = head_c ? {16'h0000, hw0} : {hw1, hw0};
    assign bus.instr_is_c    = head_c;
    assign bus.instr_pc      = pc_q;
    assign bus.instr_pc_next = pc_q + (head_c ? XLEN'(2) : XLEN'(4));
    assign bus.count         = cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            skip_lo <= RESET_PC[1];
            pc_q    <= RESET_PC & ~XLEN'(1);
            fa_q    <= RESET_PC & ~XLEN'(3);
        end else if (bus.redirect) begin
            cnt     <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            skip_lo <= bus.redirect_pc[1];
            pc_q    <= bus.redirect_pc & ~XLEN'(1);
            fa_q    <= bus.redirect_pc & ~XLEN'(3);
        end else begin
            cnt    <= cnt + push_n - pop_n;
            rd_ptr <= rd_ptr + pop_n[PW-1:0];
            wr_ptr <= wr_ptr + push_n[PW-1:0];
            if (pop)
                pc_q <= pc_q + (head_c ? XLEN'(2) : XLEN'(4));
            if (push) begin
                fa_q    <= fa_q + XLEN'(4);
                skip_lo <= 1'b0;
            end
        end
    end

    // Storage needs no reset: occupancy is tracked by cnt alone.
    always_ff @(posedge clk) begin
        if (push) begin
            if (skip_lo) begin
                hw_q[wr_ptr] <= bus.fetch_rdata[31:16];
            end else begin
                hw_q[wr_ptr]  <= bus.fetch_rdata[15:0];
                hw_q[wr_nxt1] <= bus.fetch_rdata[31:16];
            end
        end
    end
endmodule

// File: tb/tb_fetch_align_queue.sv
// Drives a DEPTH=8 and a DEPTH=4 queue with shared stimulus and checks both
// against a halfword-stream reference model every cycle.
module tb_fetch_align_queue;
    logic        clk;
    logic        rst;
    logic        gnt, ready, redirect;
    logic [31:0] rpc;
    logic [31:0] mem [0:127];
    int          checks = 0;
    int          failures = 0;

    fetch_align_queue_if #(.XLEN(32), .DEPTH(8)) b0 ();
    fetch_align_queue_if #(.XLEN(32), .DEPTH(4)) b1 ();

    fetch_align_queue #(.XLEN(32), .DEPTH(8), .RESET_PC(32'h0)) u0 (
        .clk(clk), .rst(rst), .bus(b0.slave));
    fetch_align_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h6)) u1 (
        .clk(clk), .rst(rst), .bus(b1.slave));

    assign b0.fetch_gnt   = gnt;
    assign b1.fetch_gnt   = gnt;
    assign b0.instr_ready = ready;
    assign b1.instr_ready = ready;
    assign b0.redirect    = redirect;
    assign b1.redirect    = redirect;
    assign b0.redirect_pc = rpc;
    assign b1.redirect_pc = rpc;
    assign b0.fetch_rdata = mem[b0.fetch_addr[8:2]];
    assign b1.fetch_rdata = mem[b1.fetch_addr[8:2]];

    logic        o_req [2], o_valid [2], o_isc [2];
    logic [31:0] o_fa [2], o_instr [2], o_pc [2], o_next [2], o_cnt [2];
    assign o_req[0]   = b0.fetch_req;     assign o_req[1]   = b1.fetch_req;
    assign o_valid[0] = b0.instr_valid;   assign o_valid[1] = b1.instr_valid;
    assign o_isc[0]   = b0.instr_is_c;    assign o_isc[1]   = b1.instr_is_c;
    assign o_fa[0]    = b0.fetch_addr;    assign o_fa[1]    = b1.fetch_addr;
    assign o_instr[0] = b0.instr;         assign o_instr[1] = b1.instr;
    assign o_pc[0]    = b0.instr_pc;      assign o_pc[1]    = b1.instr_pc;
    assign o_next[0]  = b0.instr_pc_next; assign o_next[1]  = b1.instr_pc_next;
    assign o_cnt[0]   = {28'd0, b0.count};
    assign o_cnt[1]   = {29'd0, b1.count};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: an unbounded halfword stream with absolute read/write counts.
    logic [15:0] mq [2][256];
    int          mrd [2], mwr [2];
    logic [31:0] mpc [2], mfa [2];
    logic        mskip [2];
    int          mdep [2]    = '{8, 4};
    logic [31:0] mrstpc [2]  = '{32'h0, 32'h6};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            int          n;
            logic [15:0] h0, h1;
            logic        isc, ev, ereq;
            logic [31:0] w, ei;
            string       p;
            p = (i == 0) ? "d8" : "d4";
            if (!rst) begin
                mrd[i] = 0; mwr[i] = 0;
                mpc[i] = mrstpc[i] & ~32'h1;
                mfa[i] = mrstpc[i] & ~32'h3;
                mskip[i] = mrstpc[i][1];
            end
            n    = mwr[i] - mrd[i];
            h0   = mq[i][mrd[i] % 256];
            h1   = mq[i][(mrd[i] + 1) % 256];
            isc  = (h0[1:0] != 2'b11);
            ev   = rst && !redirect && (isc ? n >= 1 : n >= 2);
            ereq = rst && !redirect && ((mdep[i] - n) >= (mskip[i] ? 1 : 2));
            ei   = isc ? {16'h0, h0} : {h1, h0};
            chk({p, "_count"}, o_cnt[i], n);
            chk({p, "_fetch_req"}, {31'd0, o_req[i]}, {31'd0, ereq});
            chk({p, "_fetch_addr"}, o_fa[i], mfa[i]);
            chk({p, "_instr_valid"}, {31'd0, o_valid[i]}, {31'd0, ev});
            chk({p, "_instr_pc"}, o_pc[i], mpc[i]);
            if (ev) begin
                chk({p, "_instr"}, o_instr[i], ei);
                chk({p, "_is_c"}, {31'd0, o_isc[i]}, {31'd0, isc});
                chk({p, "_pc_next"}, o_next[i], mpc[i] + (isc ? 32'd2 : 32'd4));
            end
            if (rst) begin
                if (redirect) begin
                    mrd[i] = 0; mwr[i] = 0;
                    mpc[i] = rpc & ~32'h1;
                    mfa[i] = rpc & ~32'h3;
                    mskip[i] = rpc[1];
                end else begin
                    if (ev && ready) begin
                        mrd[i] += isc ? 1 : 2;
                        mpc[i] += isc ? 32'd2 : 32'd4;
                    end
                    if (ereq && gnt) begin
                        w = mem[mfa[i][8:2]];
                        if (!mskip[i]) begin
                            mq[i][mwr[i] % 256] = w[15:0];
                            mwr[i]++;
                        end
                        mq[i][mwr[i] % 256] = w[31:16];
                        mwr[i]++;
                        mfa[i] += 32'd4;
                        mskip[i] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; gnt = 1'b1; ready = 1'b1; redirect = 1'b0; rpc = '0;
        for (int k = 0; k < 128; k++) mem[k] = $urandom;
        mem[0]  = 32'h00A00093; mem[1]  = 32'h00108113;
        mem[4]  = 32'h45014505; mem[5]  = 32'h00000001;
        mem[8]  = 32'h00934505; mem[9]  = 32'h000000A0;
        mem[24] = 32'h00108113; mem[25] = 32'h00A00093; mem[26] = 32'h00208193;
        mem[64] = 32'h45051234;

        // reset state
        sample();
        chk("rst_count", o_cnt[0], 0);
        chk("rst_req", {31'd0, o_req[0]}, 0);
        chk("rst_valid", {31'd0, o_valid[0]}, 0);
        chk("rst_addr_d4", o_fa[1], 32'h4);
        chk("rst_pc_d4", o_pc[1], 32'h6);
        adv(); rst = 1'b1;

        // two 32-bit instructions from reset
        sample(); chk("first_req", {31'd0, o_req[0]}, 1); adv();
        sample();
        chk("w0_valid", {31'd0, o_valid[0]}, 1);
        chk("w0_instr", o_instr[0], 32'h00A00093);
        chk("w0_pc", o_pc[0], 32'h0);
        chk("w0_is_c", {31'd0, o_isc[0]}, 0);
        adv();
        sample(); chk("w1_instr", o_instr[0], 32'h00108113); chk("w1_pc", o_pc[0], 32'h4); adv();

        // two compressed instructions in one word
        redirect = 1'b1; rpc = 32'h10;
        sample(); chk("redir_valid", {31'd0, o_valid[0]}, 0); chk("redir_req", {31'd0, o_req[0]}, 0);
        adv(); redirect = 1'b0;
        sample(); chk("c_cnt0", o_cnt[0], 0); chk("c_fa", o_fa[0], 32'h10); adv();
        sample();
        chk("c0_instr", o_instr[0], 32'h00004505);
        chk("c0_pc", o_pc[0], 32'h10);
        chk("c0_next", o_next[0], 32'h12);
        chk("c0_is_c", {31'd0, o_isc[0]}, 1);
        adv();
        sample(); chk("c1_instr", o_instr[0], 32'h00004501); chk("c1_pc", o_pc[0], 32'h12);
        chk("c1_count", o_cnt[0], 3); adv();

        // straddling 32-bit instruction
        redirect = 1'b1; rpc = 32'h20; sample(); adv();
        redirect = 1'b0; gnt = 1'b1; sample(); adv();
        gnt = 1'b0;
        sample(); chk("st_c_instr", o_instr[0], 32'h00004505); chk("st_c_pc", o_pc[0], 32'h20); adv();
        sample(); chk("st_wait_valid", {31'd0, o_valid[0]}, 0); chk("st_wait_cnt", o_cnt[0], 1); adv();
        gnt = 1'b1;
        sample(); chk("st_nobypass", {31'd0, o_valid[0]}, 0); adv();
        sample();
        chk("st_valid", {31'd0, o_valid[0]}, 1);
        chk("st_instr", o_instr[0], 32'h00A00093);
        chk("st_pc", o_pc[0], 32'h22);
        chk("st_next", o_next[0], 32'h26);
        adv();

        // redirect into the upper half with six halfwords queued
        ready = 1'b0; redirect = 1'b1; rpc = 32'h40; sample(); adv();
        redirect = 1'b0;
        repeat (3) begin sample(); adv(); end
        redirect = 1'b1; rpc = 32'h102;
        sample(); chk("rd6_count", o_cnt[0], 6); chk("rd6_valid", {31'd0, o_valid[0]}, 0); adv();
        redirect = 1'b0;
        sample(); chk("rd_cnt", o_cnt[0], 0); chk("rd_fa", o_fa[0], 32'h100); chk("rd_pc", o_pc[0], 32'h102); adv();
        sample(); chk("rd_hi_cnt", o_cnt[0], 1); chk("rd_hi_instr", o_instr[0], 32'h00004505); adv();

        // grant and 32-bit pop in the same cycle at count 2
        redirect = 1'b1; rpc = 32'h60; sample(); adv();
        redirect = 1'b0; sample(); adv();
        ready = 1'b1;
        sample(); chk("gp_cnt", o_cnt[0], 2); chk("gp_instr", o_instr[0], 32'h00108113); adv();
        sample(); chk("gp_cnt2", o_cnt[0], 2); chk("gp_pc", o_pc[0], 32'h64); adv();

        // fill the DEPTH=4 queue, then drain through pointer wrap
        ready = 1'b0; redirect = 1'b1; rpc = 32'h80; sample(); adv();
        redirect = 1'b0;
        repeat (5) begin sample(); adv(); end
        sample(); chk("full_cnt", o_cnt[1], 4); chk("full_req", {31'd0, o_req[1]}, 0); adv();
        ready = 1'b1;
        repeat (20) begin sample(); adv(); end

        // asynchronous reset mid-operation
        ready = 1'b0; repeat (2) begin sample(); adv(); end
        rst = 1'b0; sample(); chk("async_rst_cnt", o_cnt[0], 0); adv();
        rst = 1'b1;

        for (int c = 0; c < 4000; c++) begin
            gnt      = ($urandom_range(0, 3) != 0);
            ready    = ($urandom_range(0, 3) != 0);
            redirect = ($urandom_range(0, 29) == 0);
            rpc      = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FF00 | $urandom_range(0, 255))
                                                   : $urandom_range(0, 511);
            rst      = ($urandom_range(0, 399) != 0);
            sample();
            adv();
        end
        rst = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
